// File: rtl/lamp_pkg.sv
// lamp_pkg: shared mode and sequencer state types for the lamp pattern engine
package lamp_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, ALL_ON = 2'd1, CHASE = 2'd2, BLINK = 2'd3} lamp_mode_t;
  typedef enum logic [1:0] {IDLE, RUN, PENDING} seq_state_t;
endpackage

// File: rtl/lamp_prescaler.sv
// lamp_prescaler: divides clock into pattern steps; tick is high in the cycle before a step edge
module lamp_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);
  logic [W-1:0] count;
  assign tick = enable && !clear && count == LAST;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= tick ? '0 : count + W'(1);
endmodule

// File: rtl/lamp_sequencer.sv
// lamp_sequencer: programmable OFF/ALL_ON/CHASE/BLINK pattern engine for the indicator lamps
module lamp_sequencer
  import lamp_pkg::*;
#(
  parameter int NUM_LAMPS = 11,
  parameter int PRESCALE  = 1000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [1:0]           mode_req,
  input  logic                 mode_valid,
  output logic                 mode_ready,
  output logic [NUM_LAMPS-1:0] lamps,
  output logic                 step_pulse,
  output logic                 busy
);
  localparam int IW = $clog2(NUM_LAMPS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_LAMPS - 1);
  seq_state_t state, state_n;
  lamp_mode_t mode, mode_n, pend, pend_n, req, load_mode;
  logic [IW-1:0] idx, idx_n, idx_next;
  logic phase, phase_n, tick, accept, load;
  logic [NUM_LAMPS-1:0] lamps_n;
  assign req        = lamp_mode_t'(mode_req);
  assign mode_ready = state != PENDING;
  assign busy       = state != IDLE;
  assign accept     = mode_valid && mode_ready;
  assign step_pulse = tick;
  assign idx_next   = idx == IDX_LAST ? '0 : idx + IW'(1);
  // a pending swap on a step edge takes priority over advancing the old pattern
  assign load       = (state == IDLE && accept && req != OFF) || (state == PENDING && tick);
  assign load_mode  = state == IDLE ? req : pend;
  lamp_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (enable),
    .clear  (state == IDLE),
    .tick   (tick)
  );
  always_comb begin
    state_n = state;
    mode_n  = mode;
    pend_n  = pend;
    idx_n   = idx;
    phase_n = phase;
    lamps_n = lamps;
    if (load) begin
      mode_n  = load_mode;
      idx_n   = '0;
      phase_n = 1'b1;
      lamps_n = load_mode == OFF ? '0 : load_mode == CHASE ? NUM_LAMPS'(1) : '1;
      state_n = load_mode == OFF ? IDLE : RUN;
    end else if (state != IDLE) begin
      if (tick && mode == CHASE) begin
        idx_n   = idx_next;
        lamps_n = NUM_LAMPS'(1) << idx_next;
      end
      if (tick && mode == BLINK) begin
        phase_n = ~phase;
        lamps_n = {NUM_LAMPS{~phase}};
      end
      if (accept) begin
        pend_n  = req;
        state_n = PENDING;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      mode  <= OFF;
      pend  <= OFF;
      idx   <= '0;
      phase <= 1'b0;
      lamps <= '0;
    end else begin
      state <= state_n;
      mode  <= mode_n;
      pend  <= pend_n;
      idx   <= idx_n;
      phase <= phase_n;
      lamps <= lamps_n;
    end
endmodule

// File: tb/tb_lamp_sequencer.sv
// tb_lamp_sequencer: directed and random stimulus checked against a step-count reference model
module tb_lamp_sequencer;
  localparam int N = 11;
  localparam int P = 4;
  logic clock = 0, reset_n = 0, enable = 0, mode_valid = 0;
  logic [1:0] mode_req = 0;
  logic mode_ready, step_pulse, busy;
  logic [N-1:0] lamps;
  int errors = 0, checks = 0;
  bit m_active;
  int m_mode, m_pend, m_steps, m_cnt;
  lamp_sequencer #(.NUM_LAMPS(N), .PRESCALE(P)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .mode_req  (mode_req),
    .mode_valid(mode_valid),
    .mode_ready(mode_ready),
    .lamps     (lamps),
    .step_pulse(step_pulse),
    .busy      (busy)
  );
  always #5 clock = ~clock;
  // lamps follow from the mode and the number of steps taken since it was loaded
  function automatic logic [N-1:0] model_lamps();
    logic [N-1:0] one = 1;
    if (!m_active) return '0;
    if (m_mode == 2) return one << (m_steps % N);
    if (m_mode == 3 && m_steps % 2 == 1) return '0;
    return '1;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_active = 0;
    m_mode = 0;
    m_pend = -1;
    m_steps = 0;
    m_cnt = 0;
  endtask
  task automatic check_outputs();
    check("lamps", 32'(lamps), 32'(model_lamps()));
    check("mode_ready", 32'(mode_ready), 32'(m_pend < 0));
    check("busy", 32'(busy), 32'(m_active));
    check("step_pulse", 32'(step_pulse), 32'(m_active && enable && m_cnt == P - 1));
  endtask
  task automatic model_edge(input bit e, input bit v, input int r);
    bit acc = v && m_pend < 0;
    bit st = m_active && e && m_cnt == P - 1;
    if (!m_active) begin
      if (acc && r != 0) begin
        m_active = 1;
        m_mode = r;
        m_steps = 0;
        m_cnt = 0;
      end
    end else begin
      if (st) begin
        m_cnt = 0;
        if (m_pend >= 0) begin
          m_mode = m_pend;
          m_pend = -1;
          m_steps = 0;
          m_active = m_mode != 0;
        end else m_steps++;
      end else if (e) m_cnt++;
      if (acc) m_pend = r;
    end
  endtask
  task automatic cyc(input bit e, input bit v, input int r);
    enable = e;
    mode_valid = v;
    mode_req = 2'(r);
    #2;
    check_outputs();
    @(posedge clock);
    model_edge(e, v, r);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clock);
    #1;
    reset_n = 1;
  endtask
  task automatic wait_chase(input int idx, input int cnt);
    int n = 0;
    while (!(m_active && m_mode == 2 && m_pend < 0 && m_steps % N == idx && m_cnt == cnt) && n < 200) begin
      cyc(1, 0, 0);
      n++;
    end
    check("wait_chase", 32'(n < 200), 32'd1);
  endtask
  initial begin
    model_reset();
    #2;
    check_outputs();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
    cyc(1, 1, 2);
    repeat (P * N + 2 * P) cyc(1, 0, 0);
    wait_chase(5, 1);
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    repeat (6) cyc(1, 0, 0);
    cyc(1, 1, 2);
    repeat (6) cyc(1, 0, 0);
    repeat (10) cyc(0, 0, 0);
    repeat (8) cyc(1, 0, 0);
    do_reset();
    cyc(1, 1, 3);
    repeat (14) cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 2);
    cyc(1, 1, 2);
    repeat (6) cyc(1, 0, 0);
    cyc(1, 1, 2);
    repeat (3) cyc(1, 0, 0);
    do_reset();
    for (int i = 0; i < 800; i++)
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
